// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one req/ack bus transaction per MEM-stage access, with load extension.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              done_o,
  output logic              access_err_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StBus  = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addrR;
  logic [3:0]        beR;
  logic [31:0]       wdataR;
  logic              weR;
  logic [2:0]        funct3R;
  logic [31:0]       loadDataR;
  logic              errR;
  logic              reqOk;
  logic              timeoutHit;

  function automatic logic accessOk(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign reqOk = accessOk(req_we, req_funct3, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] toCnt;

  // Wait-cycle counter: held at zero outside BUS, counts BUS cycles without ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt <= {CntW{1'b0}};
    end else if (state != StBus) begin
      toCnt <= {CntW{1'b0}};
    end else if (!bus_ack) begin
      toCnt <= toCnt + {{(CntW-1){1'b0}}, 1'b1};
    end else begin
      toCnt <= toCnt;
    end
  end

  assign timeoutHit = (state == StBus) && !bus_ack && (toCnt == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Transaction FSM and request/response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      addrR     <= {ADDR_W{1'b0}};
      beR       <= 4'b0000;
      wdataR    <= 32'h0000_0000;
      weR       <= 1'b0;
      funct3R   <= 3'b000;
      loadDataR <= 32'h0000_0000;
      errR      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid && reqOk) begin
            addrR     <= req_addr;
            beR       <= byteEnable(req_funct3, req_addr[1:0]);
            wdataR    <= laneData(req_funct3, req_wdata);
            weR       <= req_we;
            funct3R   <= req_funct3;
            loadDataR <= 32'h0000_0000;
            errR      <= 1'b0;
            state     <= StBus;
          end
        end
        StBus: begin
          // Ack wins over a timeout landing in the same cycle.
          if (bus_ack) begin
            loadDataR <= weR ? 32'h0000_0000 : extendLoad(funct3R, addrR[1:0], bus_rdata);
            errR      <= 1'b0;
            state     <= StDone;
          end else if (timeoutHit) begin
            loadDataR <= 32'h0000_0000;
            errR      <= 1'b1;
            state     <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Output decode; illegal requests are answered combinationally from IDLE.
  always_comb begin
    stall_o      = 1'b0;
    load_data_o  = 32'h0000_0000;
    done_o       = 1'b0;
    access_err_o = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = {ADDR_W{1'b0}};
    bus_be       = 4'b0000;
    bus_wdata    = 32'h0000_0000;
    case (state)
      StIdle: begin
        if (!rst && req_valid) begin
          if (reqOk) begin
            stall_o = 1'b1;
          end else begin
            done_o       = 1'b1;
            access_err_o = 1'b1;
          end
        end else begin
          stall_o = 1'b0;
        end
      end
      StBus: begin
        stall_o   = 1'b1;
        bus_req   = 1'b1;
        bus_we    = weR;
        bus_addr  = {addrR[ADDR_W-1:2], 2'b00};
        bus_be    = beR;
        bus_wdata = wdataR;
      end
      StDone: begin
        done_o       = 1'b1;
        access_err_o = errR;
        load_data_o  = loadDataR;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: expected completions queued at request time, checked on done_o.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, done_o, access_err_o;
  logic [31:0] load_data_o;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;
  logic [32:0] sbQ[$];

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(stall_o), .load_data_o(load_data_o), .done_o(done_o), .access_err_o(access_err_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done_o pulse must match the oldest expected result.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (!rst && done_o) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkVal("load_data", load_data_o, e[31:0]);
        checkVal("access_err", {31'd0, access_err_o}, {31'd0, e[32]});
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic doAccess(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input logic [3:0] expBe, input logic [31:0] expWd,
                          input logic [31:0] expLd);
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive(we, f3, addr, wd);
    sbQ.push_back({1'b0, expLd});
    #1;
    if (stall_o) stalls++;
    @(negedge clk);
    #1;
    checkVal({tag, "_req"}, {31'd0, bus_req}, 32'd1);
    checkVal({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    checkVal({tag, "_be"}, {28'd0, bus_be}, {28'd0, expBe});
    checkVal({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
    if (we) checkVal({tag, "_wdata"}, bus_wdata, expWd);
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (stall_o) stalls++;
      if (i == waits) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
    end
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    req_valid = 1'b0;
    #1;
    checkVal({tag, "_done_stall"}, {31'd0, stall_o}, 32'd0);
    checkVal({tag, "_stalls"}, 32'(stalls), 32'(2 + waits));
  endtask

  task automatic doIllegal(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
    @(negedge clk);
    drive(we, f3, addr, 32'h1234_5678);
    sbQ.push_back({1'b1, 32'h0});
    #1;
    checkVal({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    checkVal({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checkVal({tag, "_req_after"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    int busCycles;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_outputs", {stall_o, done_o, access_err_o, bus_req, bus_we, bus_be},
             32'd0);
    rst = 1'b0;

    doAccess("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
    doAccess("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
    doAccess("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'h00000080);
    doAccess("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, 4'b1100, 32'h0, 32'h00008011);
    doAccess("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, 4'b1100, 32'h0, 32'hFFFF8011);
    doAccess("lb100", 1'b0, 3'b000, 32'h100, 32'h0, 32'h8000007F, 0, 4'b0001, 32'h0, 32'h0000007F);
    doAccess("sh206", 1'b1, 3'b001, 32'h206, 32'h0000ABCD, 32'hFFFFFFFF, 3, 4'b1100, 32'hABCDABCD, 32'h0);
    doAccess("sb101", 1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    doAccess("sw208", 1'b1, 3'b010, 32'h208, 32'h12345678, 32'h0, 1, 4'b1111, 32'h12345678, 32'h0);

    doIllegal("lw_mis", 1'b0, 3'b010, 32'h101);
    doIllegal("f3_011", 1'b0, 3'b011, 32'h100);
    doIllegal("lh_mis", 1'b0, 3'b001, 32'h105);
    doIllegal("st_f3_100", 1'b1, 3'b100, 32'h100);

    // Reset on the second BUS cycle of a load.
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h103, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkVal("rst_mid_bus_ctl", {stall_o, done_o, access_err_o, bus_req, bus_we, bus_be}, 32'd0);
    checkVal("rst_mid_bus_data", load_data_o | bus_addr | bus_wdata, 32'd0);
    rst = 1'b0;
    doAccess("lw_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h300, 32'h0);
    sbQ.push_back({1'b1, 32'h0});
    busCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus_req) busCycles++;
      else break;
    end
    req_valid = 1'b0;
    checkVal("timeout_bus_cycles", 32'(busCycles), 32'd4);
    if (busCycles >= 20) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
`else
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h300, 32'h0);
    busCycles = 0;
    repeat (100) @(negedge clk);
    #1;
    checkVal("no_timeout_stall", {31'd0, stall_o}, 32'd1);
    checkVal("no_timeout_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #3;
    checkVal("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
